dma_desc_scheduler: RTL and testbench

DMA_DESC_SCHEDULER -- requirements
Module: dma_desc_scheduler

---
 rtl/dma_pkg.sv | 25 ++
 rtl/dma_desc_fifo.sv | 91 +++++++++
 rtl/dma_desc_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_dma_desc_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA descriptor scheduler: FSM state encoding,
// descriptor field widths and a helper that computes the packed descriptor
// width for a given address width.
// -----------------------------------------------------------------------------
package dma_pkg;

    // Width of the byte-count field of a descriptor.
    localparam int SIZE_W     = 32;
    // Width of the completed-descriptor counter.
    localparam int DONE_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } dma_state_e;

    // Packed descriptor layout is {src, dst, size}.
    function automatic int desc_width(input int addr_w);
        return (2 * addr_w) + SIZE_W;
    endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// -----------------------------------------------------------------------------
// dma_desc_fifo
// Synchronous descriptor queue. Storage, pointers and count are all flops, so
// rd_data (the head entry) comes straight from registers with no path from the
// write side. Push while full and pop while empty are ignored.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wr_data write request and entry
//   pop           remove head entry
//   rd_data       current head entry
//   count         number of stored entries (0..DEPTH)
//   full, empty   queue status
// -----------------------------------------------------------------------------
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int DW    = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            wr_data,
    input  logic                     pop,
    output logic [DW-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == CW'(0));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wr_data;
            // DEPTH is a power of two, so the pointer wraps naturally.
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dma_desc_scheduler.sv
// -----------------------------------------------------------------------------
// dma_desc_scheduler
// Queues DMA descriptors and hands them one at a time to a DMA engine.
// IDLE pops the queue head into the engine registers, ACTIVE holds dma_start
// high until the engine reports dma_done, RELEASE waits for dma_done to drop
// before another descriptor may be issued. A watchdog flags ACTIVE phases that
// last TIMEOUT cycles; zero-length descriptors are dropped and flagged.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   desc_valid/desc_ready            descriptor handshake
//   desc_src/desc_dst/desc_size      descriptor fields
//   dma_start                        engine start/hold (registered)
//   src_addr/dst_addr/transfer_size  descriptor presented to the engine
//   dma_done, dma_error              engine status
//   busy                             a descriptor is in flight
//   fifo_count                       queued (not yet issued) descriptors
//   done_count                       completed descriptors, wraps
//   irq / irq_clear                  completion interrupt and its clear
//   err_sticky / err_clear           error latch and its clear
// -----------------------------------------------------------------------------
module dma_desc_scheduler
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic [ADDR_WIDTH-1:0]   desc_src,
    input  logic [ADDR_WIDTH-1:0]   desc_dst,
    input  logic [31:0]             desc_size,
    output logic                    dma_start,
    output logic [ADDR_WIDTH-1:0]   src_addr,
    output logic [ADDR_WIDTH-1:0]   dst_addr,
    output logic [31:0]             transfer_size,
    input  logic                    dma_done,
    input  logic                    dma_error,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [15:0]             done_count,
    output logic                    irq,
    input  logic                    irq_clear,
    output logic                    err_sticky,
    input  logic                    err_clear
);

    localparam int DW  = desc_width(ADDR_WIDTH);
    localparam int WDW = $clog2(TIMEOUT + 1);

    dma_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [SIZE_W-1:0]       size_q, size_d;
    logic [WDW-1:0]          wdog_q, wdog_d;
    logic [DONE_CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    irq_q, irq_d;
    logic                    err_q, err_d;

    logic                    accept_s, zero_size_s, push_s, pop_s;
    logic                    irq_set_s, wdog_err_s, err_set_s;
    logic                    fifo_full_s, fifo_empty_s;
    logic [DW-1:0]           head_s;

    // Ready is a decode of the queue count only; no bypass when full.
    assign desc_ready  = !fifo_full_s;
    assign accept_s    = desc_valid && desc_ready;
    assign zero_size_s = (desc_size == 32'd0);
    assign push_s      = accept_s && !zero_size_s;

    dma_desc_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data ({desc_src, desc_dst, desc_size}),
        .pop     (pop_s),
        .rd_data (head_s),
        .count   (fifo_count),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // FSM next state, descriptor capture, watchdog and completion count.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        size_d     = size_q;
        wdog_d     = wdog_q;
        done_cnt_d = done_cnt_q;
        pop_s      = 1'b0;
        irq_set_s  = 1'b0;
        wdog_err_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // dma_done is deliberately not looked at here.
                if (!fifo_empty_s) begin
                    pop_s                  = 1'b1;
                    {src_d, dst_d, size_d} = head_s;
                    wdog_d                 = WDW'(0);
                    state_d                = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (dma_done) begin
                    state_d    = ST_RELEASE;
                    done_cnt_d = done_cnt_q + 16'd1;
                    irq_set_s  = 1'b1;
                end else begin
                    state_d = ST_ACTIVE;
                    // Watchdog saturates at TIMEOUT; the error fires once,
                    // on the cycle the count reaches the limit.
                    if (wdog_q == WDW'(TIMEOUT)) begin
                        wdog_d = wdog_q;
                    end else begin
                        wdog_d = wdog_q + WDW'(1);
                        if (wdog_q == WDW'(TIMEOUT - 1)) begin
                            wdog_err_s = 1'b1;
                        end else begin
                            wdog_err_s = 1'b0;
                        end
                    end
                end
            end
            ST_RELEASE: begin
                // Engine must drop dma_done before the next issue.
                if (!dma_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags; a set event on the same edge as a clear wins.
    always_comb begin
        err_set_s = wdog_err_s
                  || (accept_s && zero_size_s)
                  || (dma_error && (state_q != ST_IDLE));
        if (irq_set_s) begin
            irq_d = 1'b1;
        end else if (irq_clear) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        // Decoding from the next state keeps these outputs registered
        // while still lining up with the state they describe.
        start_d = (state_d == ST_ACTIVE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Scheduler state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            size_q     <= 32'd0;
            wdog_q     <= WDW'(0);
            done_cnt_q <= 16'd0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            size_q     <= size_d;
            wdog_q     <= wdog_d;
            done_cnt_q <= done_cnt_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
            err_q      <= err_d;
        end
    end

    assign dma_start     = start_q;
    assign src_addr      = src_q;
    assign dst_addr      = dst_q;
    assign transfer_size = size_q;
    assign busy          = busy_q;
    assign done_count    = done_cnt_q;
    assign irq           = irq_q;
    assign err_sticky    = err_q;

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dma_desc_scheduler
// Directed scenarios plus a randomized run. Accepted non-zero descriptors are
// pushed into an expected-issue queue; a monitor pops that queue whenever
// dma_start rises and compares the presented descriptor, and every cycle
// compares fifo_count/desc_ready with the model's queue occupancy. An engine
// process answers dma_start with dma_done after a random delay.
// -----------------------------------------------------------------------------
module tb_dma_desc_scheduler;

    localparam int AW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 1024;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] size;
    } desc_t;

    logic                   clk;
    logic                   rst;
    logic                   desc_valid;
    logic                   desc_ready;
    logic [AW-1:0]          desc_src;
    logic [AW-1:0]          desc_dst;
    logic [31:0]            desc_size;
    logic                   dma_start;
    logic [AW-1:0]          src_addr;
    logic [AW-1:0]          dst_addr;
    logic [31:0]            transfer_size;
    logic                   dma_done;
    logic                   dma_error;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0]            done_count;
    logic                   irq;
    logic                   irq_clear;
    logic                   err_sticky;
    logic                   err_clear;

    int          n_checks  = 0;
    int          n_errors  = 0;
    desc_t       exp_q[$];
    logic [15:0] exp_done  = 16'd0;
    bit          mon_en    = 1'b0;
    bit          engine_en = 1'b0;

    dma_desc_scheduler #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_src      (desc_src),
        .desc_dst      (desc_dst),
        .desc_size     (desc_size),
        .dma_start     (dma_start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .transfer_size (transfer_size),
        .dma_done      (dma_done),
        .dma_error     (dma_error),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .done_count    (done_count),
        .irq           (irq),
        .irq_clear     (irq_clear),
        .err_sticky    (err_sticky),
        .err_clear     (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer a descriptor; it is accepted at the posedge following a negedge
    // on which desc_ready is seen high. Returns just after the accept edge.
    task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z,
                             input int budget, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        desc_valid = 1'b1;
        desc_src   = s;
        desc_dst   = d;
        desc_size  = z;
        for (int i = 0; i < budget && !ok; i++) begin
            if (desc_ready) begin
                @(posedge clk);
                if (z != 32'd0) exp_q.push_back('{s, d, z});
                ok = 1'b1;
                #1;
            end else begin
                @(negedge clk);
            end
        end
        desc_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (dma_start) seen = 1'b1;
        end
        if (!seen) check({name, "_start_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            if (!busy && !dma_done && exp_q.size() == 0) seen = 1'b1;
        end
        if (!seen) check({name, "_idle_timeout"}, 64'd0, 64'd1);
    endtask

    // Engine model: answers dma_start with a dma_done held 1..3 cycles.
    initial begin : engine
        int unsigned dly;
        int unsigned hold;
        forever begin
            @(negedge clk);
            if (engine_en && dma_start && !dma_done && !rst) begin
                dly  = $urandom_range(0, 4);
                hold = $urandom_range(1, 3);
                repeat (dly) @(negedge clk);
                dma_done = 1'b1;
                exp_done = exp_done + 16'd1;
                repeat (hold) @(negedge clk);
                dma_done = 1'b0;
            end
        end
    end

    // Monitor: issue order/contents, hold stability and queue occupancy.
    initial begin : monitor
        logic  prev_start;
        desc_t cur;
        desc_t e;
        prev_start = 1'b0;
        cur        = '{32'd0, 32'd0, 32'd0};
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (dma_start && !prev_start) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_issue", 64'd1, 64'd0);
                    end else begin
                        e   = exp_q.pop_front();
                        cur = e;
                        check("issue_src", src_addr, e.src);
                        check("issue_dst", dst_addr, e.dst);
                        check("issue_size", transfer_size, e.size);
                    end
                end else if (dma_start) begin
                    check("hold_src", src_addr, cur.src);
                    check("hold_dst", dst_addr, cur.dst);
                    check("hold_size", transfer_size, cur.size);
                end
                check("fifo_count", fifo_count, exp_q.size());
                check("desc_ready", desc_ready, exp_q.size() != DEPTH);
            end
            prev_start = dma_start;
        end
    end

    initial begin : global_guard
        #900000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin : main
        bit          ok;
        logic [31:0] rs, rdst, rz;
        int          gap;

        rst = 1'b1; desc_valid = 1'b0; desc_src = '0; desc_dst = '0; desc_size = 32'd0;
        dma_done = 1'b0; dma_error = 1'b0; irq_clear = 1'b0; err_clear = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_start", dma_start, 0);
        check("rst_src", src_addr, 0);
        check("rst_dst", dst_addr, 0);
        check("rst_size", transfer_size, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_done_count", done_count, 0);
        check("rst_irq", irq, 0);
        check("rst_err", err_sticky, 0);
        check("rst_ready", desc_ready, 1);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single descriptor: start two edges after accept, done pulse.
        push_desc(32'h1000, 32'h2000, 32'd64, 10, ok);
        check("p1_accept", ok, 1);
        @(negedge clk);
        check("p1_start_edge1", dma_start, 0);
        @(negedge clk);
        check("p1_start_edge2", dma_start, 1);
        check("p1_src", src_addr, 32'h1000);
        check("p1_dst", dst_addr, 32'h2000);
        check("p1_size", transfer_size, 32'd64);
        check("p1_busy", busy, 1);
        dma_done  = 1'b1;
        irq_clear = 1'b1;
        exp_done  = exp_done + 16'd1;
        @(negedge clk);
        dma_done  = 1'b0;
        irq_clear = 1'b0;
        check("p1_start_low", dma_start, 0);
        check("p1_done_count", done_count, exp_done);
        check("p1_irq_set_wins", irq, 1);
        check("p1_busy_release", busy, 1);
        @(negedge clk);
        check("p1_busy_idle", busy, 0);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        check("p1_irq_clear", irq, 0);

        // dma_done while idle is ignored.
        dma_done = 1'b1;
        @(negedge clk);
        dma_done = 1'b0;
        @(negedge clk);
        check("idle_done_count", done_count, exp_done);
        check("idle_done_irq", irq, 0);
        check("idle_done_start", dma_start, 0);

        // Zero-size descriptor: dropped, flags an error.
        push_desc(32'h3000, 32'h4000, 32'd0, 10, ok);
        check("z_accept", ok, 1);
        @(negedge clk);
        check("z_err_set", err_sticky, 1);
        check("z_fifo_count", fifo_count, 0);
        repeat (3) @(negedge clk);
        check("z_no_start", dma_start, 0);
        check("z_not_busy", busy, 0);
        err_clear = 1'b1;
        push_desc(32'h3004, 32'h4004, 32'd0, 10, ok);
        err_clear = 1'b0;
        check("z2_accept", ok, 1);
        @(negedge clk);
        check("z_err_set_wins", err_sticky, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("z_err_clear", err_sticky, 0);

        // Engine stalled: five back-to-back, queue fills while first in flight.
        engine_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_desc(32'h5000 + 32'(k * 16), 32'h6000 + 32'(k * 16), 32'd16 + 32'(k), 10, ok);
            check("q_accept", ok, 1);
        end
        @(negedge clk);
        check("q_full_count", fifo_count, DEPTH);
        check("q_full_ready", desc_ready, 0);
        check("q_first_inflight", dma_start, 1);
        push_desc(32'h7000, 32'h8000, 32'd99, 4, ok);
        check("q_full_reject", ok, 0);
        engine_en = 1'b1;
        push_desc(32'h7000, 32'h8000, 32'd99, 300, ok);
        check("q_accept_after_pop", ok, 1);
        wait_idle("q");
        check("q_done_count", done_count, exp_done);

        // dma_done held 3 cycles: no reissue until it drops.
        engine_en = 1'b0;
        push_desc(32'hA000, 32'hB000, 32'd8, 10, ok);
        check("h_accept_a", ok, 1);
        push_desc(32'hA100, 32'hB100, 32'd9, 10, ok);
        check("h_accept_b", ok, 1);
        wait_start("h");
        dma_done = 1'b1;
        exp_done = exp_done + 16'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("h_held_no_issue", dma_start, 0);
        end
        dma_done = 1'b0;
        @(negedge clk);
        check("h_after_drop_idle", dma_start, 0);
        check("h_after_drop_busy", busy, 0);
        @(negedge clk);
        check("h_reissue", dma_start, 1);
        dma_done = 1'b1;
        exp_done = exp_done + 16'd1;
        @(negedge clk);
        dma_done = 1'b0;
        wait_idle("h");
        check("h_done_count", done_count, exp_done);

        // Watchdog: error exactly when ACTIVE has lasted TIMEOUT cycles.
        push_desc(32'hC000, 32'hD000, 32'd128, 10, ok);
        check("w_accept", ok, 1);
        wait_start("w");
        check("w_err_initial", err_sticky, 0);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("w_err_early", err_sticky, 0);
        @(negedge clk);
        check("w_err_at_timeout", err_sticky, 1);
        check("w_start_held", dma_start, 1);
        repeat (1100 - TIMEOUT) @(negedge clk);
        check("w_start_still", dma_start, 1);
        check("w_busy_still", busy, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("w_err_saturated_clear", err_sticky, 0);
        dma_error = 1'b1;
        @(negedge clk);
        dma_error = 1'b0;
        check("w_dma_error_sets", err_sticky, 1);
        check("w_dma_error_state", dma_start, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        dma_done  = 1'b1;
        exp_done  = exp_done + 16'd1;
        @(negedge clk);
        dma_done  = 1'b0;
        wait_idle("w");
        check("w_done_count", done_count, exp_done);

        // Reset while ACTIVE with two entries queued.
        push_desc(32'hE000, 32'hF000, 32'd1, 10, ok);
        push_desc(32'hE100, 32'hF100, 32'd2, 10, ok);
        push_desc(32'hE200, 32'hF200, 32'd3, 10, ok);
        @(negedge clk);
        check("r_pre_count", fifo_count, 2);
        check("r_pre_start", dma_start, 1);
        mon_en   = 1'b0;
        rst      = 1'b1;
        dma_done = 1'b1;
        @(negedge clk);
        check("r_start", dma_start, 0);
        check("r_fifo_count", fifo_count, 0);
        check("r_done_count", done_count, 0);
        check("r_busy", busy, 0);
        check("r_irq", irq, 0);
        check("r_ready", desc_ready, 1);
        exp_q.delete();
        exp_done = 16'd0;
        dma_done = 1'b0;
        rst      = 1'b0;
        mon_en   = 1'b1;

        // Randomized traffic against the engine model.
        engine_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rs   = $urandom;
            rdst = $urandom;
            rz   = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
            push_desc(rs, rdst, rz, 400, ok);
            check("rand_accept", ok, 1);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        wait_idle("rand");
        check("rand_done_count", done_count, exp_done);
        check("rand_fifo_empty", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
